axi_up_sched: RTL
=================

# axi_up_sched

Job scheduler for the user-plugin copy engine: it shares the engine's register-level command interface among `NUM_REQ` requesters. Each requester presents a copy job (source, destination, size) with a valid/ready handshake. The scheduler grants requesters round-robin, loads the engine's address and size inputs, pulses trigger, and tracks engine busy until the job completes. It then returns a one-cycle done pulse to the granted requester. It sits between the plugin's client logic and the engine's `src_addr`/`dst_addr`/`size`/`trigger`/`busy` nets.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ADDR_WIDTH`, 32: address width; matches the engine's AXI address width.
- `SIZE_WIDTH`, 15: transfer size width in bytes; matches the engine's size register.
- `TIMEOUT_CYCLES`, 65535: watchdog limit. Used only with `AXI_UP_SCHED_TIMEOUT_EN`.

Ports:
- `ACLK`  in  1  clock; all logic is on the rising edge.
- `ARESET`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester job valid.
- `req_ready_o`  out  NUM_REQ  per-requester job accept; at most one bit high.
- `req_src_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed source addresses; requester i occupies slice i.
- `req_dst_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed destination addresses.
- `req_size_i`  in  NUM_REQ*SIZE_WIDTH  packed sizes.
- `done_o`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `err_o`  out  1  qualifies `done_o`; 1 means the job timed out.
- `src_addr_o`  out  ADDR_WIDTH  engine source address, registered.
- `dst_addr_o`  out  ADDR_WIDTH  engine destination address, registered.
- `size_o`  out  SIZE_WIDTH  engine size, registered.
- `trigger_pulse_o`  out  1  engine start command; one cycle.
- `busy_i`  in  1  engine busy status.
- `sched_busy_o`  out  1  high in every state except IDLE.
- `grant_idx_o`  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
States: IDLE, TRIG, WAIT_BUSY, WAIT_DONE, DONE.

- **IDLE:** when any `req_valid_i` is set and `busy_i`=0, pick requester g by round-robin.
  - Search starts at the priority pointer and wraps modulo NUM_REQ.
  - `req_ready_o[g]`=1 combinationally in that cycle; the handshake completes there.
  - Latch g and the requester's src/dst/size into the `*_o` registers.
  - Set the priority pointer to (g+1) mod NUM_REQ.
  - If the latched size is 0, go to DONE. Otherwise go to TRIG.
- **IDLE with `busy_i`=1:** no grant. The engine is in use through its direct register path.
- **TRIG:** `trigger_pulse_o`=1 for exactly one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `busy_i`=1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `busy_i`=0, then go to DONE.
- **DONE:** `done_o[g]`=1 for one cycle, with `err_o` set as described below. Then go to IDLE.
- **Error flag:** `err_o`=0 unless the job timed out.
- **Ready rule:** `req_ready_o` is 0 in every state other than IDLE.
- **Stability:** `src_addr_o`, `dst_addr_o` and `size_o` hold their values from load until the next grant.
- **Requester rule:** a requester must keep valid and payload stable until it sees ready.
- **Reset:** all registered outputs are 0, the state is IDLE and the pointer is 0.
  - Reset taken mid-job abandons the job; no `done_o` is issued.

## Timing
- Grant to trigger: 1 cycle (handshake in cycle N, trigger in cycle N+1).
- Engine busy falling to `done_o`: 1 cycle; the pulse is in the cycle after `busy_i` is sampled low.
- Zero-size job: `done_o` is high in the cycle after the handshake.
- Back-to-back jobs: the next grant comes no earlier than the cycle after DONE.
- Minimum spacing between triggers is therefore 4 cycles plus the engine's busy time.
- Round-robin fairness: no requester waits more than NUM_REQ−1 jobs while it holds valid.

## Configuration
- `AXI_UP_SCHED_TIMEOUT_EN` defined:
  - A cycle counter is cleared on entry to WAIT_BUSY and counts through WAIT_BUSY and WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE with `err_o`=1.
  - The engine is not touched on timeout.
- `AXI_UP_SCHED_TIMEOUT_EN` undefined:
  - No counter is built and `err_o` is tied to 0.
  - WAIT_BUSY and WAIT_DONE wait indefinitely.

## Structure
- Package `axi_up_sched_pkg` holds:
  - the state enum `sched_state_e`;
  - the default widths `ADDR_WIDTH`, `SIZE_WIDTH`, `TIMEOUT_CYCLES`.
- Sub-module `axi_up_sched_rr_arb`: a combinational round-robin arbiter.
  - Inputs: `req` (NUM_REQ bits) and the priority pointer.
  - Outputs: a one-hot `gnt`, `gnt_idx` and `gnt_valid`.
  - The pointer register itself lives in the parent.

## Test plan
- Single job: requester 1 sends src=0x1000, dst=0x2000, size=64, and the engine model holds busy for 10 cycles.
  - Expect ready in cycle 0, trigger in cycle 1, `size_o`=64, and done[1] one cycle after busy falls.
- Four requesters valid together from reset: grants in order 0,1,2,3.
  - Requester 0 then re-asserts valid while 1–3 are still pending: its next grant comes only after 3.
- Zero-size job from requester 2: no trigger; done[2]=1 in the cycle after the handshake, with `err_o`=0.
- `busy_i` held high in IDLE with requester 0 valid: no ready until `busy_i` drops, then a grant in that same cycle.
- With the macro defined and `TIMEOUT_CYCLES`=16, the engine never asserts busy.
  - Expect done=1 with `err_o`=1 after 16 cycles in WAIT_BUSY. The next job then proceeds normally.
- `ARESET` pulsed while in WAIT_DONE:
  - all outputs go to 0 asynchronously and no done is issued;
  - after release, requester 0 has top priority.

Source files
------------

// File: rtl/axi_up_sched_pkg.sv
// Shared state type and default widths for the axi_up_sched copy-engine job scheduler.
package axi_up_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } sched_state_e;

  localparam int ADDR_WIDTH     = 32;
  localparam int SIZE_WIDTH     = 15;
  localparam int TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/axi_up_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo NUM_REQ.
module axi_up_sched_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_valid
);
  import axi_up_sched_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the closest match to ptr is the last one written.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        gnt_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
        gnt       = NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_up_sched.sv
// Round-robin job scheduler sharing the copy engine's command nets among NUM_REQ requesters.
// Optional watchdog on the engine wait states: define AXI_UP_SCHED_TIMEOUT_EN.
//
// state       | meaning
// ------------+-------------------------------------------------
// S_IDLE      | waiting for a valid job while the engine is free
// S_TRIG      | one-cycle engine start pulse
// S_WAIT_BUSY | waiting for the engine to report busy
// S_WAIT_DONE | waiting for the engine to drop busy
// S_DONE      | one-cycle done pulse to the granted requester
module axi_up_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = axi_up_sched_pkg::ADDR_WIDTH,
  parameter int SIZE_WIDTH     = axi_up_sched_pkg::SIZE_WIDTH,
  parameter int TIMEOUT_CYCLES = axi_up_sched_pkg::TIMEOUT_CYCLES
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr_i,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0] req_size_i,
  output logic [NUM_REQ-1:0]            done_o,
  output logic                          err_o,
  output logic [ADDR_WIDTH-1:0]         src_addr_o,
  output logic [ADDR_WIDTH-1:0]         dst_addr_o,
  output logic [SIZE_WIDTH-1:0]         size_o,
  output logic                          trigger_pulse_o,
  input  logic                          busy_i,
  output logic                          sched_busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx_o
);
  import axi_up_sched_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e          r_state;
  sched_state_e          w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_grant;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [SIZE_WIDTH-1:0] r_size;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_gnt_valid;
  logic                  w_take;
  logic                  w_to_fire;
  logic [ADDR_WIDTH-1:0] w_src_sel;
  logic [ADDR_WIDTH-1:0] w_dst_sel;
  logic [SIZE_WIDTH-1:0] w_size_sel;

  axi_up_sched_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid_i),
    .ptr       (r_ptr),
    .gnt       (w_gnt),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  // Engine busy in IDLE means someone is using its direct register path; hold off granting.
  assign w_take = (r_state == S_IDLE) && !busy_i && w_gnt_valid;

  always_comb begin
    w_src_sel  = '0;
    w_dst_sel  = '0;
    w_size_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_src_sel  = req_src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_dst_sel  = req_dst_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_size_sel = req_size_i[i*SIZE_WIDTH +: SIZE_WIDTH];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_grant <= w_gnt_idx;
        r_src   <= w_src_sel;
        r_dst   <= w_dst_sel;
        r_size  <= w_size_sel;
        r_ptr   <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    req_ready_o     = '0;
    trigger_pulse_o = 1'b0;
    done_o          = '0;
    sched_busy_o    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          req_ready_o = w_gnt;
          w_state_nxt = (w_size_sel == '0) ? S_DONE : S_TRIG;
        end
      end
      S_TRIG: begin
        trigger_pulse_o = 1'b1;
        w_state_nxt     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (w_to_fire)   w_state_nxt = S_DONE;
        else if (busy_i) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!busy_i || w_to_fire) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = NUM_REQ'(1) << r_grant;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef AXI_UP_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic            w_waiting;

  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  // A job that finishes in the same cycle the watchdog expires counts as a clean completion.
  assign w_to_fire = (r_to_cnt == '0) &&
                     ((r_state == S_WAIT_BUSY) || ((r_state == S_WAIT_DONE) && busy_i));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_TRIG)
        r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
      else if (w_waiting && (r_to_cnt != '0))
        r_to_cnt <= r_to_cnt - 1'b1;
      if (w_take)
        r_err <= 1'b0;
      else if (w_waiting)
        r_err <= w_to_fire;
    end
  end

  assign err_o = (r_state == S_DONE) && r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_to_fire        = 1'b0;
  assign err_o            = 1'b0;
`endif

  assign src_addr_o  = r_src;
  assign dst_addr_o  = r_dst;
  assign size_o      = r_size;
  assign grant_idx_o = r_grant;

endmodule
